// File: rtl/bit_stream_packer.sv
// ============================================================================
// Module   : bit_stream_packer
// Brief    : Packs a qualified serial bit stream into WIDTH-bit words with a
//            one-cycle strobe; flushes a zero-padded partial word on last_i.
// Option   : BIT_STREAM_PACKER_MSB_FIRST_EN places the first bit at the MSB.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bit_stream_packer #(
   parameter int WIDTH = 16
) (
   input  logic                     clk_i,
   input  logic                     srst_i,
   input  logic                     data_i,
   input  logic                     data_val_i,
   input  logic                     last_i,
   output logic [WIDTH-1:0]         data_o,
   output logic                     data_val_o,
   output logic [$clog2(WIDTH):0]   data_mod_o
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam int MOD_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

   logic [WIDTH-1:0] asm_q, asm_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             val_q, val_d;
   logic [MOD_W-1:0] mod_q, mod_d;

   logic [CNT_W-1:0] bit_pos;
   logic [WIDTH-1:0] word_next;
   logic             word_done;

`ifdef BIT_STREAM_PACKER_MSB_FIRST_EN
   assign bit_pos = LAST_IDX - cnt_q;
`else
   assign bit_pos = cnt_q;
`endif

   // The assembly register is cleared at every word boundary, so unwritten
   // positions of a flushed partial word are already zero.
   always_comb begin
      word_next          = asm_q;
      word_next[bit_pos] = data_i;
   end

   assign word_done = (cnt_q == LAST_IDX) || last_i;

   always_comb begin
      asm_d  = asm_q;
      cnt_d  = cnt_q;
      data_d = data_q;
      mod_d  = mod_q;
      val_d  = 1'b0;
      if (data_val_i) begin
         if (word_done) begin
            data_d = word_next;
            mod_d  = MOD_W'(cnt_q) + MOD_W'(1);
            val_d  = 1'b1;
            cnt_d  = '0;
            asm_d  = '0;
         end else begin
            asm_d  = word_next;
            cnt_d  = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         asm_q  <= '0;
         cnt_q  <= '0;
         data_q <= '0;
         mod_q  <= '0;
         val_q  <= 1'b0;
      end else begin
         asm_q  <= asm_d;
         cnt_q  <= cnt_d;
         data_q <= data_d;
         mod_q  <= mod_d;
         val_q  <= val_d;
      end
   end

   assign data_o     = data_q;
   assign data_val_o = val_q;
   assign data_mod_o = mod_q;

endmodule

`default_nettype wire

// File: tb/tb_bit_stream_packer.sv
// ============================================================================
// Module   : tb_bit_stream_packer
// Brief    : Directed self-checking bench for bit_stream_packer (WIDTH=16).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bit_stream_packer;

   localparam int WIDTH = 16;

`ifdef BIT_STREAM_PACKER_MSB_FIRST_EN
   localparam logic [15:0] EXP_ALT   = 16'hAAAA;  // 1,0,1,0,... first bit at MSB
   localparam logic [15:0] EXP_PART  = 16'hF800;
   localparam logic [15:0] EXP_TOP   = 16'h0001;  // only 16th bit set
   localparam logic [15:0] EXP_FIRST = 16'h8000;  // only 1st bit set
   localparam logic [15:0] EXP_ODD   = 16'h5555;  // 0,1,0,1,...
`else
   localparam logic [15:0] EXP_ALT   = 16'h5555;
   localparam logic [15:0] EXP_PART  = 16'h001F;
   localparam logic [15:0] EXP_TOP   = 16'h8000;
   localparam logic [15:0] EXP_FIRST = 16'h0001;
   localparam logic [15:0] EXP_ODD   = 16'hAAAA;
`endif

   logic        clk = 1'b0;
   logic        srst_i = 1'b1;
   logic        data_i = 1'b0;
   logic        data_val_i = 1'b0;
   logic        last_i = 1'b0;
   logic [15:0] data_o;
   logic        data_val_o;
   logic [4:0]  data_mod_o;

   int n_assert = 0;
   int n_fail   = 0;

   bit_stream_packer #(.WIDTH(WIDTH)) dut (
      .clk_i      (clk),
      .srst_i     (srst_i),
      .data_i     (data_i),
      .data_val_i (data_val_i),
      .last_i     (last_i),
      .data_o     (data_o),
      .data_val_o (data_val_o),
      .data_mod_o (data_mod_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle, then check the strobe right after the sampling edge.
   task automatic send(input string tag, input logic d, input logic v, input logic l,
                       input logic rst, input logic exp_val);
      data_i = d; data_val_i = v; last_i = l; srst_i = rst;
      @(posedge clk);
      #1;
      chk(tag, {31'd0, data_val_o}, {31'd0, exp_val});
   endtask

   task automatic chk_word(input string tag, input logic [15:0] exp_data, input logic [4:0] exp_mod);
      chk({tag, "_data"}, {16'd0, data_o}, {16'd0, exp_data});
      chk({tag, "_mod"}, {27'd0, data_mod_o}, {27'd0, exp_mod});
   endtask

   initial begin
      int gap;

      // Reset state
      send("rst_val", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      send("rst_val", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk_word("rst", 16'h0000, 5'd0);

      // Full word 1,0,1,0,...
      for (int i = 0; i < 16; i++)
         send("full_val", (i % 2 == 0), 1'b1, 1'b0, 1'b0, (i == 15));
      chk_word("full", EXP_ALT, 5'd16);
      send("full_after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk_word("full_hold", EXP_ALT, 5'd16);

      // Partial frame: five ones, last on the fifth
      for (int i = 0; i < 5; i++)
         send("part_val", 1'b1, 1'b1, (i == 4), 1'b0, (i == 4));
      chk_word("part", EXP_PART, 5'd5);

      // Gaps with last_i asserted while data_val_i is low
      for (int i = 0; i < 16; i++) begin
         gap = $urandom_range(0, 5);
         for (int g = 0; g < gap; g++)
            send("gap_idle", 1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b0, 1'b0);
         send("gap_val", (i % 2 == 0), 1'b1, 1'b0, 1'b0, (i == 15));
      end
      chk_word("gap", EXP_ALT, 5'd16);
      for (int g = 0; g < 3; g++)
         send("gap_tail", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

      // Reset mid-word, with a valid bit dropped during reset
      for (int i = 0; i < 7; i++)
         send("rmid_pre", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      send("rmid_rst", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      chk_word("rmid_rst", 16'h0000, 5'd0);
      for (int i = 0; i < 16; i++) begin
         send("rmid_val", 1'b1, 1'b1, 1'b0, 1'b0, (i == 15));
         if (i < 15) chk_word("rmid_zero", 16'h0000, 5'd0);
      end
      chk_word("rmid", 16'hFFFF, 5'd16);

      // Completing bit coincident with reset: no strobe
      for (int i = 0; i < 15; i++)
         send("rwin_pre", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      send("rwin_rst", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      send("rwin_after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk_word("rwin", 16'h0000, 5'd0);

      // Simultaneous completion: last on 16th bit, then one-bit frame
      for (int i = 0; i < 15; i++)
         send("sim_pre", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      send("sim_w1", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      chk_word("sim_w1", EXP_TOP, 5'd16);
      send("sim_w2", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      chk_word("sim_w2", EXP_FIRST, 5'd1);
      send("sim_after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Back-to-back: ones, then 0,1,0,1..., then zeros
      for (int i = 0; i < 48; i++) begin
         logic b;
         b = (i < 16) ? 1'b1 : (i < 32) ? (i % 2 == 1) : 1'b0;
         send("b2b_val", b, 1'b1, 1'b0, 1'b0, (i % 16 == 15));
         if (i == 15) chk_word("b2b_w0", 16'hFFFF, 5'd16);
         if (i == 31) chk_word("b2b_w1", EXP_ODD, 5'd16);
         if (i == 47) chk_word("b2b_w2", 16'h0000, 5'd16);
      end
      send("b2b_after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
